// File: rtl/bp_pkg.sv
// Shared types, counter constants and the saturating-counter helper for the branch predictor.
// Counter helpers take the counter width as an argument so parametrised instances can use them.
package bp_pkg;

    localparam int BP_ADDR_W = 32;
    localparam int BP_SETS   = 64;
    localparam int BP_IDX_W  = $clog2(BP_SETS);
    localparam int BP_TAG_W  = BP_ADDR_W - BP_IDX_W - 2;
    localparam int BP_CTR_W  = 2;
    localparam int CTR_MAX_W = 16;

    localparam logic [BP_CTR_W-1:0] CTR_WEAK_NT = BP_CTR_W'((1 << (BP_CTR_W - 1)) - 1);
    localparam logic [BP_CTR_W-1:0] CTR_WEAK_T  = BP_CTR_W'(1 << (BP_CTR_W - 1));

    // Entry layout at the default geometry; the top rebuilds the same layout from its parameters.
    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_ADDR_W-1:0] target;
        logic [BP_CTR_W-1:0] ctr;
    } btb_entry_t;

    function automatic logic [CTR_MAX_W-1:0] ctr_weak_t(input int width);
        return CTR_MAX_W'(1) << (width - 1);
    endfunction

    function automatic logic [CTR_MAX_W-1:0] ctr_weak_nt(input int width);
        return ctr_weak_t(width) - CTR_MAX_W'(1);
    endfunction

    function automatic logic [CTR_MAX_W-1:0] sat_update(input logic [CTR_MAX_W-1:0] ctr,
                                                         input logic taken,
                                                         input int width);
        logic [CTR_MAX_W-1:0] max_val;
        max_val = ctr_weak_t(width) | ctr_weak_nt(width);
        if (taken)
            return (ctr == max_val) ? ctr : ctr + CTR_MAX_W'(1);
        else
            return (ctr == '0) ? ctr : ctr - CTR_MAX_W'(1);
    endfunction

endpackage

// File: rtl/bp_set_match.sv
// Combinational tag compare across the ways of one set.
// Reports the matching way plus the lowest-numbered free way for allocation.
module bp_set_match #(
    parameter int WAYS  = 2,
    parameter int TAG_W = 24,
    parameter int WAY_W = 1
) (
    input  logic [WAYS-1:0]       way_valid,
    input  logic [WAYS*TAG_W-1:0] way_tags,
    input  logic [TAG_W-1:0]      tag,
    output logic                  hit,
    output logic [WAY_W-1:0]      hit_way,
    output logic [WAY_W-1:0]      first_invalid_way,
    output logic                  any_invalid
);

    logic [WAYS-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_cmp
            assign match[gi] = way_valid[gi] && (way_tags[gi*TAG_W +: TAG_W] == tag);
        end
    endgenerate

    // Scan from the top way down so the lowest-numbered candidate wins.
    always_comb begin
        hit               = |match;
        any_invalid       = ~&way_valid;
        hit_way           = '0;
        first_invalid_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w])
                hit_way = WAY_W'(w);
            if (!way_valid[w])
                first_invalid_way = WAY_W'(w);
        end
    end

endmodule

// File: rtl/btb_sa_predictor.sv
// Set-associative BTB with per-entry saturating direction counters and round-robin replacement.
// Define BTB_GSHARE_EN to take direction from a GHR-indexed pattern history table instead.
module btb_sa_predictor
    import bp_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int SETS   = 64,
    parameter int WAYS   = 2,
    parameter int CTR_W  = 2,
    parameter int GHR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              pred_valid,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'(ctr_weak_nt(CTR_W));
    localparam logic [CTR_W-1:0] WEAK_T  = CTR_W'(ctr_weak_t(CTR_W));

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
`ifndef BTB_GSHARE_EN
        logic [CTR_W-1:0]  ctr;
`endif
    } entry_t;

    entry_t           entry_reg [SETS][WAYS];
    logic [WAY_W-1:0] rr_reg    [SETS];

    logic              pred_valid_reg;
    logic              pred_hit_reg;
    logic              pred_taken_reg;
    logic [ADDR_W-1:0] pred_target_reg;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;

    assign lk_idx = lookup_addr[IDX_W+1:2];
    assign lk_tag = lookup_addr[ADDR_W-1:IDX_W+2];
    assign up_idx = upd_addr[IDX_W+1:2];
    assign up_tag = upd_addr[ADDR_W-1:IDX_W+2];

    wire unused_addr_lsbs = &{1'b0, lookup_addr[1:0], upd_addr[1:0]};

    logic [WAYS-1:0]       lk_way_valid, up_way_valid;
    logic [WAYS*TAG_W-1:0] lk_way_tags,  up_way_tags;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_flat
            assign lk_way_valid[gi]                = entry_reg[lk_idx][gi].valid;
            assign lk_way_tags[gi*TAG_W +: TAG_W]  = entry_reg[lk_idx][gi].tag;
            assign up_way_valid[gi]                = entry_reg[up_idx][gi].valid;
            assign up_way_tags[gi*TAG_W +: TAG_W]  = entry_reg[up_idx][gi].tag;
        end
    endgenerate

    logic             lk_hit, lk_any_invalid;
    logic [WAY_W-1:0] lk_hit_way, lk_first_invalid;
    logic             up_hit, up_any_invalid;
    logic [WAY_W-1:0] up_hit_way, up_first_invalid;

    bp_set_match #(.WAYS(WAYS), .TAG_W(TAG_W), .WAY_W(WAY_W)) u_lookup_match (
        .way_valid         (lk_way_valid),
        .way_tags          (lk_way_tags),
        .tag               (lk_tag),
        .hit               (lk_hit),
        .hit_way           (lk_hit_way),
        .first_invalid_way (lk_first_invalid),
        .any_invalid       (lk_any_invalid)
    );

    bp_set_match #(.WAYS(WAYS), .TAG_W(TAG_W), .WAY_W(WAY_W)) u_update_match (
        .way_valid         (up_way_valid),
        .way_tags          (up_way_tags),
        .tag               (up_tag),
        .hit               (up_hit),
        .hit_way           (up_hit_way),
        .first_invalid_way (up_first_invalid),
        .any_invalid       (up_any_invalid)
    );

    wire unused_lk_alloc = &{1'b0, lk_first_invalid, lk_any_invalid};

    entry_t lk_entry;
    logic   lk_taken;

`ifdef BTB_GSHARE_EN
    logic [GHR_W-1:0] ghr_reg;
    logic [CTR_W-1:0] pht_reg [SETS];
    logic [IDX_W-1:0] pht_lk_idx, pht_up_idx;

    assign pht_lk_idx = lk_idx ^ ghr_reg[IDX_W-1:0];
    assign pht_up_idx = up_idx ^ ghr_reg[IDX_W-1:0];

    // The PHT trains on every resolved branch with the pre-shift history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_reg <= '0;
            for (int s = 0; s < SETS; s++)
                pht_reg[s] <= WEAK_NT;
        end else if (upd_valid) begin
            pht_reg[pht_up_idx] <= CTR_W'(sat_update(CTR_MAX_W'(pht_reg[pht_up_idx]), upd_taken, CTR_W));
            ghr_reg             <= {ghr_reg[GHR_W-2:0], upd_taken};
        end
    end

    always_comb begin
        lk_entry = entry_reg[lk_idx][lk_hit_way];
        lk_taken = pht_reg[pht_lk_idx][CTR_W-1];
    end
`else
    always_comb begin
        lk_entry = entry_reg[lk_idx][lk_hit_way];
        lk_taken = lk_entry.ctr[CTR_W-1];
    end
`endif

    // Outputs are registered from pre-update state, which gives read-before-write for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid_reg  <= 1'b0;
            pred_hit_reg    <= 1'b0;
            pred_taken_reg  <= 1'b0;
            pred_target_reg <= '0;
        end else begin
            pred_valid_reg  <= lookup_valid;
            pred_hit_reg    <= lookup_valid && lk_hit;
            pred_taken_reg  <= lookup_valid && lk_hit && lk_taken;
            pred_target_reg <= (lookup_valid && lk_hit) ? lk_entry.target : '0;
        end
    end

    assign pred_valid  = pred_valid_reg;
    assign pred_hit    = pred_hit_reg;
    assign pred_taken  = pred_taken_reg;
    assign pred_target = pred_target_reg;

    entry_t           rst_entry, alloc_entry;
    logic [WAY_W-1:0] victim_way;

    always_comb begin
        rst_entry          = '0;
        alloc_entry        = '0;
        alloc_entry.valid  = 1'b1;
        alloc_entry.tag    = up_tag;
        alloc_entry.target = upd_target;
`ifndef BTB_GSHARE_EN
        rst_entry.ctr      = WEAK_NT;
        alloc_entry.ctr    = WEAK_T;
`endif
        victim_way = up_any_invalid ? up_first_invalid : rr_reg[up_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                rr_reg[s] <= '0;
                for (int w = 0; w < WAYS; w++)
                    entry_reg[s][w] <= rst_entry;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
`ifndef BTB_GSHARE_EN
                entry_reg[up_idx][up_hit_way].ctr <=
                    CTR_W'(sat_update(CTR_MAX_W'(entry_reg[up_idx][up_hit_way].ctr), upd_taken, CTR_W));
`endif
                if (upd_taken)
                    entry_reg[up_idx][up_hit_way].target <= upd_target;
            end else if (upd_taken) begin
                entry_reg[up_idx][victim_way] <= alloc_entry;
                // The pointer only advances when a live entry was actually displaced.
                if (WAYS > 1 && !up_any_invalid)
                    rr_reg[up_idx] <= rr_reg[up_idx] + WAY_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_btb_sa_predictor.sv
// Directed bench for btb_sa_predictor: per-cycle compare against a behavioural model,
// plus hand-computed literal expectations for the test-plan scenarios.
module tb_btb_sa_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_addr = '0;
    logic        pred_valid, pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_addr = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;

    int checks = 0;
    int errors = 0;

    btb_sa_predictor dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_valid (lookup_valid),
        .lookup_addr  (lookup_addr),
        .pred_valid   (pred_valid),
        .pred_hit     (pred_hit),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .upd_valid    (upd_valid),
        .upd_addr     (upd_addr),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: 64 sets x 2 ways, counters as plain integers 0..3.
    bit          m_valid  [64][2];
    int unsigned m_tag    [64][2];
    int unsigned m_target [64][2];
    int          m_ctr    [64][2];
    int          m_rr     [64];

    function automatic int set_of(input int unsigned a);
        return (a >> 2) % 64;
    endfunction

    function automatic int find_way(input int unsigned a);
        for (int w = 0; w < 2; w++)
            if (m_valid[set_of(a)][w] && m_tag[set_of(a)][w] == (a >> 8))
                return w;
        return -1;
    endfunction

    always @(posedge clk) begin
        bit          e_valid, e_hit, e_taken;
        int unsigned e_target;
        int          s, w;
        e_valid = 0; e_hit = 0; e_taken = 0; e_target = 0;
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                m_rr[i] = 0;
                for (int j = 0; j < 2; j++) begin
                    m_valid[i][j] = 0;
                    m_ctr[i][j]   = 1;
                end
            end
        end else begin
            if (lookup_valid) begin
                e_valid = 1;
                w = find_way(lookup_addr);
                if (w >= 0) begin
                    e_hit    = 1;
                    e_taken  = m_ctr[set_of(lookup_addr)][w] >= 2;
                    e_target = m_target[set_of(lookup_addr)][w];
                end
            end
            if (upd_valid) begin
                s = set_of(upd_addr);
                w = find_way(upd_addr);
                if (w >= 0) begin
                    if (upd_taken) begin
                        if (m_ctr[s][w] < 3) m_ctr[s][w]++;
                        m_target[s][w] = upd_target;
                    end else if (m_ctr[s][w] > 0) begin
                        m_ctr[s][w]--;
                    end
                end else if (upd_taken) begin
                    if (!m_valid[s][0])      w = 0;
                    else if (!m_valid[s][1]) w = 1;
                    else begin
                        w = m_rr[s];
                        m_rr[s] = (m_rr[s] + 1) % 2;
                    end
                    m_valid[s][w]  = 1;
                    m_tag[s][w]    = upd_addr >> 8;
                    m_target[s][w] = upd_target;
                    m_ctr[s][w]    = 2;
                end
            end
        end
        #1;
        chk("model_valid",  32'(pred_valid),  32'(e_valid));
        chk("model_hit",    32'(pred_hit),    32'(e_hit));
        chk("model_taken",  32'(pred_taken),  32'(e_taken));
        chk("model_target", pred_target,      e_target);
    end

    task automatic do_upd(input logic [31:0] a, input logic t, input logic [31:0] tgt);
        @(negedge clk);
        upd_valid = 1'b1; upd_addr = a; upd_taken = t; upd_target = tgt;
        @(negedge clk);
        upd_valid = 1'b0;
        $display("update  addr=0x%08h taken=%0d target=0x%08h", a, t, tgt);
    endtask

    task automatic do_lookup(input string name, input logic [31:0] a,
                             input logic e_hit, input logic e_taken, input logic [31:0] e_tgt);
        @(negedge clk);
        lookup_valid = 1'b1; lookup_addr = a;
        @(negedge clk);
        lookup_valid = 1'b0;
        chk({name, "_valid"},  32'(pred_valid),  32'd1);
        chk({name, "_hit"},    32'(pred_hit),    32'(e_hit));
        chk({name, "_taken"},  32'(pred_taken),  32'(e_taken));
        chk({name, "_target"}, pred_target,      e_tgt);
        $display("lookup  addr=0x%08h hit=%0d taken=%0d target=0x%08h", a, pred_hit, pred_taken, pred_target);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_valid",  32'(pred_valid), 32'd0);
        chk("reset_target", pred_target,     32'd0);
        rst = 1'b0;

        // 1: cold miss
        do_lookup("cold", 32'h0000_1000, 0, 0, 32'h0);

        // 2: allocate on taken, no allocation on not-taken miss
        do_upd(32'h1000, 1, 32'h2000);
        do_lookup("alloc", 32'h1000, 1, 1, 32'h2000);
        do_upd(32'h1040, 0, 32'h5555);
        do_lookup("nt_noalloc", 32'h1040, 0, 0, 32'h0);

        // 3: counter walks down and saturates, then up and saturates
        do_upd(32'h1000, 0, 32'h0);
        do_lookup("ctr1", 32'h1000, 1, 0, 32'h2000);
        do_upd(32'h1000, 0, 32'h0);
        do_lookup("ctr0", 32'h1000, 1, 0, 32'h2000);
        do_upd(32'h1000, 0, 32'h0);
        do_lookup("ctr0_sat", 32'h1000, 1, 0, 32'h2000);
        do_upd(32'h1000, 1, 32'h2400);
        do_lookup("ctr1_up", 32'h1000, 1, 0, 32'h2400);
        for (int i = 0; i < 3; i++)
            do_upd(32'h1000, 1, 32'h2400);
        do_lookup("ctr3_sat", 32'h1000, 1, 1, 32'h2400);

        // 4: fill set 0 and evict way 0 through the round-robin pointer
        do_upd(32'h1000, 1, 32'h2400);
        do_upd(32'h2000, 1, 32'h2222);
        do_upd(32'h3000, 1, 32'h3333);
        do_lookup("evicted", 32'h1000, 0, 0, 32'h0);
        do_lookup("way1",    32'h2000, 1, 1, 32'h2222);
        do_lookup("way0",    32'h3000, 1, 1, 32'h3333);

        // 5: simultaneous lookup and allocating update see pre-update state
        @(negedge clk);
        lookup_valid = 1'b1; lookup_addr = 32'h4000;
        upd_valid = 1'b1; upd_addr = 32'h4000; upd_taken = 1'b1; upd_target = 32'h4444;
        @(negedge clk);
        lookup_valid = 1'b0; upd_valid = 1'b0;
        chk("rbw_valid", 32'(pred_valid), 32'd1);
        chk("rbw_hit",   32'(pred_hit),   32'd0);
        $display("lookup  addr=0x00004000 (same-cycle update) hit=%0d", pred_hit);
        do_lookup("rbw_after", 32'h4000, 1, 1, 32'h4444);
        do_lookup("rr_evict1", 32'h2000, 0, 0, 32'h0);

        // 6: asynchronous reset during an in-flight lookup
        @(negedge clk);
        lookup_valid = 1'b1; lookup_addr = 32'h3000;
        @(posedge clk);
        #2;
        chk("pre_rst_valid", 32'(pred_valid), 32'd1);
        rst = 1'b1;
        lookup_valid = 1'b0;
        #1;
        chk("async_rst_valid",  32'(pred_valid),  32'd0);
        chk("async_rst_hit",    32'(pred_hit),    32'd0);
        chk("async_rst_target", pred_target,      32'd0);
        $display("reset   asserted mid-lookup pred_valid=%0d", pred_valid);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_lookup("post_rst_3000", 32'h3000, 0, 0, 32'h0);
        do_lookup("post_rst_4000", 32'h4000, 0, 0, 32'h0);
        do_lookup("post_rst_1000", 32'h1000, 0, 0, 32'h0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btb_sa_predictor.md
Name: btb_sa_predictor

Overview:
- Parametrised set-associative branch target buffer with per-entry saturating direction counters; successor to the fully associative 2048-entry BTB.
- Sits in fetch. Fetch presents the PC; the registered prediction (hit, taken, target) returns one cycle later.
- Execute presents resolved branches on a separate update port. Adds configurable sets/ways/counter width, tag storage, true allocation with replacement, and read-before-write ordering.

Parameters:
ADDR_W, 32, PC/target width
SETS, 64, number of sets (power of 2); IDX_W = log2(SETS)
WAYS, 2, ways per set (power of 2, >=1)
CTR_W, 2, direction counter width (>=2)
GHR_W, 8, global history width (used only with BTB_GSHARE_EN; must be >= IDX_W)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
lookup_valid  in  1  fetch lookup request
lookup_addr  in  ADDR_W  fetch PC
pred_valid  out  1  prediction valid (one cycle after lookup_valid)
pred_hit  out  1  tag match in indexed set
pred_taken  out  1  predicted taken (counter MSB) when hit, else 0
pred_target  out  ADDR_W  stored target when hit, else 0
upd_valid  in  1  resolved branch update
upd_addr  in  ADDR_W  resolved branch PC
upd_taken  in  1  actual direction
upd_target  in  ADDR_W  actual target

Behaviour:
- Address split:
  - index = addr[IDX_W+1:2]
  - tag = addr[ADDR_W-1:IDX_W+2]
  - addr[1:0] is ignored.
- Entry fields: valid, tag, target, ctr[CTR_W-1:0]. Each set also holds a round-robin victim pointer rr[log2(WAYS)-1:0] (absent when WAYS=1).
- Reset (async, rst=1):
  - All valid=0, ctr=2^(CTR_W-1)-1 (weakly not-taken), rr=0, GHR=0.
  - pred_valid/pred_hit/pred_taken=0, pred_target=0.
  - An in-flight lookup is discarded.
- Lookup:
  - When lookup_valid is sampled at edge N, the outputs at edge N are registered.
  - pred_valid=1 for exactly one cycle; pred_valid=0 in cycles without a request.
  - Hit = any way with valid && tag match. More than one match is impossible by construction.
  - When pred_valid=0, pred_hit/taken/target are driven 0.
- Update (upd_valid=1, applied at clock edge):
  - Tag hit:
    - Counter saturating +1 if taken, -1 if not; holds at 2^CTR_W-1 and at 0.
    - Target overwritten with upd_target only when upd_taken=1.
    - rr is unchanged.
  - Tag miss and upd_taken=1: allocate.
    - Victim = lowest-numbered invalid way; if none, way rr, and rr increments modulo WAYS.
    - Allocated entry gets valid=1, tag, target=upd_target, ctr=2^(CTR_W-1) (weakly taken).
  - Tag miss and upd_taken=0: no change.
- Simultaneous lookup and update to the same entry or set in the same cycle: lookup returns pre-update state (read-before-write); the update is visible from the next lookup onward.
- One update per cycle; no backpressure; both ports are always ready.

Optional Feature:
BTB_GSHARE_EN
- Defined:
  - Direction comes from a separate pattern history table of SETS CTR_W-bit counters, indexed by index XOR GHR[IDX_W-1:0]; per-entry ctr fields are not implemented.
  - The update uses the GHR value before the shift.
  - On every upd_valid, the GHR shifts left and upd_taken enters the LSB.
  - pred_taken = PHT MSB when hit.
  - Allocation and replacement are unchanged; the PHT is not reinitialised on allocation.
- Undefined: per-entry counters as above; no GHR or PHT logic.

Decomposition:
- Package bp_pkg:
  - btb_entry_t struct (valid, tag, target, ctr), parameterised via localparam widths.
  - Constants CTR_WEAK_NT / CTR_WEAK_T.
  - Function sat_update(ctr, taken).
- Sub-module bp_set_match: combinational tag compare over one set's WAYS entries, returning hit, hit_way, first_invalid_way and any_invalid. It is instantiated twice, once for the lookup port and once for the update port.

Test Plan:
All scenarios use defaults (SETS=64, WAYS=2, CTR_W=2).
1. Reset, then lookup 0x0000_1000 -> next cycle pred_valid=1, hit=0, taken=0, target=0x0.
2. Update 0x1000 taken, target 0x2000; then lookup 0x1000 -> hit=1, taken=1 (ctr=2), target=0x2000. Update 0x1040 not-taken, then lookup -> hit=0 (no allocation).
3. Starting from scenario 2:
   - Not-taken updates on 0x1000 x3 -> ctr 1, 0, 0; taken=0, hit=1.
   - Taken x4 -> ctr saturates at 3; taken=1.
4. Taken updates 0x1000, 0x2000, 0x3000 (all index 0) -> third evicts way 0. Lookups: 0x1000 miss, 0x2000 hit, 0x3000 hit; rr=1.
5. Same cycle: lookup 0x4000 and taken update 0x4000 -> that lookup misses; the following lookup hits with target=upd_target.
6. Fill entries, assert rst mid-lookup -> pred_valid=0 immediately. After release, every previously stored address misses.
